lc3_int_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller for the LC-3 core. It generalises the single IRQ/INTP/INTV path into NUM_CH independently latched, maskable channels. Each channel has its own priority and vector. The controller arbitrates pending channels against the current PSR priority and presents one request, vector and priority to control, held until an acknowledge handshake completes.

---
 rtl/lc3_intc_pkg.sv | 26 ++
 rtl/lc3_intc_arbiter.sv | 51 +++++
 rtl/lc3_int_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_lc3_int_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_intc_pkg
// Description : Shared types and default constants for the LC-3 multi-channel
//               interrupt controller (controller FSM state encoding, default
//               priority width and vector-table base).
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_intc_pkg;

    // Controller handshake states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2
    } intc_state_t;

    // Vector-table base; the per-channel vector is OR-ed into the low bits.
    localparam logic [15:0] INTC_VEC_BASE = 16'h0100;

    // Priority width, matching PSR[10:8].
    localparam int INTC_PRI_W = 3;

endpackage : lc3_intc_pkg
`default_nettype wire

// File: rtl/lc3_intc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lc3_intc_arbiter
// Description : Purely combinational priority arbiter. Picks the eligible
//               channel with the highest priority; ties go to the lowest
//               channel index.
// Ports       : eligible_i  - per-channel eligibility vector
//               pri_i       - flattened priorities, channel i at [i*PRI_W +: PRI_W]
//               any_valid_o - at least one channel is eligible
//               win_idx_o   - index of the winning channel
//               win_pri_o   - priority of the winning channel
// Config      : none
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_intc_arbiter #(
    parameter  int NUM_CH = 4,
    parameter  int PRI_W  = 3,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0]       eligible_i,
    input  logic [NUM_CH*PRI_W-1:0] pri_i,
    output logic                    any_valid_o,
    output logic [CH_W-1:0]         win_idx_o,
    output logic [PRI_W-1:0]        win_pri_o
);

    logic              found;
    logic [CH_W-1:0]   best_idx;
    logic [PRI_W-1:0]  best_pri;

    // Ascending scan with a strict greater-than compare: an equal priority
    // found later never displaces an earlier (lower-index) winner.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_pri = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (eligible_i[i] && (!found || (pri_i[i*PRI_W +: PRI_W] > best_pri))) begin
                found    = 1'b1;
                best_idx = CH_W'(i);
                best_pri = pri_i[i*PRI_W +: PRI_W];
            end
        end
    end

    assign any_valid_o = found;
    assign win_idx_o   = best_idx;
    assign win_pri_o   = best_pri;

endmodule : lc3_intc_arbiter
`default_nettype wire

// File: rtl/lc3_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_int_ctrl
// Description : Multi-channel interrupt controller for the LC-3 core.
//               NUM_CH maskable channels with static per-channel priority and
//               vector. Pending channels above the current PSR priority are
//               arbitrated; the winner is presented to control and held until
//               acknowledged (or until it stops being eligible).
// Ports       : clk, rst_n           - clock, async active-low reset
//               irq                  - per-channel request lines
//               ch_pri / ch_vec      - flattened per-channel priority / vector
//               cur_pri              - current processor priority
//               mask_we / mask_din   - mask register write port (1 = enabled)
//               int_ack              - control accepts presented interrupt
//               int_req/int_pri/int_vec/int_ch - presented request
//               pending / mask       - status readback
// Config      : INTC_LEVEL_MODE_EN - when defined, channels are
//               level-sensitive (pending = irq & mask, nothing latched);
//               otherwise requests are rising-edge latched.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_int_ctrl
    import lc3_intc_pkg::*;
#(
    parameter  int          NUM_CH   = 4,
    parameter  int          PRI_W    = INTC_PRI_W,
    parameter  int          VEC_W    = 8,
    parameter  logic [15:0] VEC_BASE = INTC_VEC_BASE,
    localparam int          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       irq,
    input  logic [NUM_CH*PRI_W-1:0] ch_pri,
    input  logic [NUM_CH*VEC_W-1:0] ch_vec,
    input  logic [PRI_W-1:0]        cur_pri,
    input  logic                    mask_we,
    input  logic [NUM_CH-1:0]       mask_din,
    input  logic                    int_ack,
    output logic                    int_req,
    output logic [PRI_W-1:0]        int_pri,
    output logic [15:0]             int_vec,
    output logic [CH_W-1:0]         int_ch,
    output logic [NUM_CH-1:0]       pending,
    output logic [NUM_CH-1:0]       mask
);

    intc_state_t        state_q, state_d;
    logic               req_q,   req_d;
    logic [PRI_W-1:0]   pri_q,   pri_d;
    logic [15:0]        vec_q,   vec_d;
    logic [CH_W-1:0]    ch_q,    ch_d;
    logic [NUM_CH-1:0]  mask_q;

    logic [NUM_CH-1:0]  pend;
    logic [NUM_CH-1:0]  eligible;
    logic               any_valid;
    logic [CH_W-1:0]    win_idx;
    logic [PRI_W-1:0]   win_pri;
    logic [VEC_W-1:0]   win_vec;
    logic [15:0]        win_vec_ext;

    // ------------------------------------------------------------------
    // Mask register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_din;
        end
    end

    // ------------------------------------------------------------------
    // Pending sources
    // ------------------------------------------------------------------
`ifdef INTC_LEVEL_MODE_EN
    // Level mode: the source holds irq until serviced; nothing is latched.
    assign pend = irq & mask_q;
`else
    logic [NUM_CH-1:0] irq_q;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ack_clr;

    // The new edge is OR-ed in after the clear so that a channel re-edging
    // in its own acknowledge cycle stays pending and re-requests later.
    always_comb begin
        ack_clr = '0;
        if ((state_q == REQ) && int_ack) begin
            ack_clr[ch_q] = 1'b1;
        end
        pending_d = (pending_q & ~ack_clr) | (irq & ~irq_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q     <= '0;
            pending_q <= '0;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
        end
    end

    assign pend = pending_q;
`endif

    // ------------------------------------------------------------------
    // Eligibility and arbitration
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_elig
        assign eligible[i] = pend[i] & mask_q[i] & (ch_pri[i*PRI_W +: PRI_W] > cur_pri);
    end

    lc3_intc_arbiter #(
        .NUM_CH (NUM_CH),
        .PRI_W  (PRI_W)
    ) u_arbiter (
        .eligible_i  (eligible),
        .pri_i       (ch_pri),
        .any_valid_o (any_valid),
        .win_idx_o   (win_idx),
        .win_pri_o   (win_pri)
    );

    assign win_vec = ch_vec[win_idx*VEC_W +: VEC_W];

    // Bits above VEC_W come only from VEC_BASE.
    always_comb begin
        win_vec_ext              = '0;
        win_vec_ext[VEC_W-1:0]   = win_vec;
    end

    // ------------------------------------------------------------------
    // Request FSM. Output fields are zeroed whenever int_req is dropped so
    // they read 0 outside a presented request.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pri_d   = pri_q;
        vec_d   = vec_q;
        ch_d    = ch_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    pri_d   = win_pri;
                    vec_d   = VEC_BASE | win_vec_ext;
                    ch_d    = win_idx;
                end
            end
            REQ: begin
                // Presented request is frozen: no pre-emption while waiting.
                if (int_ack) begin
                    state_d = ACK;
                    req_d   = 1'b0;
                    pri_d   = '0;
                    vec_d   = '0;
                    ch_d    = '0;
                end else if (!eligible[ch_q]) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    pri_d   = '0;
                    vec_d   = '0;
                    ch_d    = '0;
                end
            end
            ACK: begin
                // One guaranteed low cycle of int_req between requests.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                pri_d   = '0;
                vec_d   = '0;
                ch_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            pri_q   <= '0;
            vec_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pri_q   <= pri_d;
            vec_q   <= vec_d;
            ch_q    <= ch_d;
        end
    end

    assign int_req = req_q;
    assign int_pri = pri_q;
    assign int_vec = vec_q;
    assign int_ch  = ch_q;
    assign pending = pend;
    assign mask    = mask_q;

endmodule : lc3_int_ctrl
`default_nettype wire

// File: tb/tb_lc3_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_int_ctrl
// Description : Directed self-checking bench for lc3_int_ctrl (NUM_CH = 4).
//               Channel priorities {ch3..ch0} = {1,5,5,2}, vectors 8'h80+i.
//               Inputs change 1 time unit after the rising edge; outputs are
//               checked at the same point, after registers have settled.
// Config      : INTC_LEVEL_MODE_EN selects the level-mode sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_int_ctrl;

    localparam int NUM_CH = 4;
    localparam int PRI_W  = 3;
    localparam int VEC_W  = 8;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_CH-1:0]       irq;
    logic [NUM_CH*PRI_W-1:0] ch_pri;
    logic [NUM_CH*VEC_W-1:0] ch_vec;
    logic [PRI_W-1:0]        cur_pri;
    logic                    mask_we;
    logic [NUM_CH-1:0]       mask_din;
    logic                    int_ack;
    logic                    int_req;
    logic [PRI_W-1:0]        int_pri;
    logic [15:0]             int_vec;
    logic [1:0]              int_ch;
    logic [NUM_CH-1:0]       pending;
    logic [NUM_CH-1:0]       mask;

    int n_checks;
    int n_errors;

    lc3_int_ctrl #(
        .NUM_CH   (NUM_CH),
        .PRI_W    (PRI_W),
        .VEC_W    (VEC_W),
        .VEC_BASE (16'h0100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .ch_pri   (ch_pri),
        .ch_vec   (ch_vec),
        .cur_pri  (cur_pri),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .int_ack  (int_ack),
        .int_req  (int_req),
        .int_pri  (int_pri),
        .int_vec  (int_vec),
        .int_ch   (int_ch),
        .pending  (pending),
        .mask     (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mask(input logic [NUM_CH-1:0] m);
        mask_we  = 1'b1;
        mask_din = m;
        tick();
        mask_we  = 1'b0;
    endtask

    task automatic check_req(input string tag, input logic [1:0] ch,
                             input logic [2:0] pri, input logic [15:0] vec);
        check({tag, ".req"}, 32'(int_req), 32'd1);
        check({tag, ".ch"},  32'(int_ch),  32'(ch));
        check({tag, ".pri"}, 32'(int_pri), 32'(pri));
        check({tag, ".vec"}, 32'(int_vec), 32'(vec));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".req"}, 32'(int_req), 32'd0);
        check({tag, ".vec"}, 32'(int_vec), 32'd0);
        check({tag, ".pri"}, 32'(int_pri), 32'd0);
    endtask

    // Acknowledge the presented request and step through ACK back to IDLE.
    task automatic ack_and_drain();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        irq      = '0;
        ch_pri   = {3'd1, 3'd5, 3'd5, 3'd2};
        ch_vec   = {8'h83, 8'h82, 8'h81, 8'h80};
        cur_pri  = '0;
        mask_we  = 1'b0;
        mask_din = '0;
        int_ack  = 1'b0;

        tick();
        tick();
        check_idle("reset");
        check("reset.pending", 32'(pending), 32'd0);
        check("reset.mask",    32'(mask),    32'd0);
        check("reset.ch",      32'(int_ch),  32'd0);

        rst_n = 1'b1;
        tick();
        write_mask(4'hF);
        check("mask.load", 32'(mask), 32'hF);

`ifdef INTC_LEVEL_MODE_EN
        // Level mode: request one edge after irq goes high.
        irq = 4'b0001;
        check("lvl.pending", 32'(pending), 32'h1);
        tick();
        check_req("lvl.first", 2'd0, 3'd2, 16'h0180);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check_idle("lvl.ack");
        check("lvl.ack.pending", 32'(pending), 32'h1);
        tick();
        check_idle("lvl.idle");
        tick();
        check_req("lvl.again", 2'd0, 3'd2, 16'h0180);
        irq = 4'b0000;
        check("lvl.drop.pending", 32'(pending), 32'h0);
        tick();
        check_idle("lvl.drop");
        tick();
        check_idle("lvl.stay");
`else
        // Single edge on channel 1: pending after 1 edge, request after 2.
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        check("t1.pending", 32'(pending), 32'h2);
        check("t1.req0",    32'(int_req), 32'd0);
        tick();
        check_req("t1.present", 2'd1, 3'd5, 16'h0181);
        tick();
        check_req("t1.hold", 2'd1, 3'd5, 16'h0181);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("t1.ack.pending", 32'(pending), 32'h0);
        check_idle("t1.ack");
        tick();
        check_idle("t1.idle");
        tick();
        check_idle("t1.stay");

        // Simultaneous equal-priority edges: lower index first.
        irq = 4'b0110;
        tick();
        irq = 4'b0000;
        check("t2.pending", 32'(pending), 32'h6);
        tick();
        check_req("t2.first", 2'd1, 3'd5, 16'h0181);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        check("t2.ack.pending", 32'(pending), 32'h4);
        check("t2.gap.req", 32'(int_req), 32'd0);
        tick();
        check("t2.idle.req", 32'(int_req), 32'd0);
        tick();
        check_req("t2.second", 2'd2, 3'd5, 16'h0182);
        ack_and_drain();
        check("t2.done.pending", 32'(pending), 32'h0);

        // Priority threshold is strict; raising cur_pri withdraws a request.
        cur_pri = 3'd5;
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        check("t3.blocked.req", 32'(int_req), 32'd0);
        check("t3.blocked.pending", 32'(pending), 32'h4);
        cur_pri = 3'd4;
        tick();
        check_req("t3.unblocked", 2'd2, 3'd5, 16'h0182);
        cur_pri = 3'd6;
        tick();
        check_idle("t3.withdrawn");
        check("t3.withdrawn.pending", 32'(pending), 32'h4);
        cur_pri = 3'd0;
        tick();
        check_req("t3.resume", 2'd2, 3'd5, 16'h0182);
        ack_and_drain();

        // Masked channel latches but does not request until unmasked.
        write_mask(4'b1110);
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick();
        tick();
        check("t4.masked.pending", 32'(pending), 32'h1);
        check("t4.masked.req", 32'(int_req), 32'd0);
        write_mask(4'hF);
        check("t4.unmask.req", 32'(int_req), 32'd0);
        tick();
        check_req("t4.present", 2'd0, 3'd2, 16'h0180);
        ack_and_drain();

        // Channel 3 re-edges in its own ack cycle: set wins.
        irq = 4'b1000;
        tick();
        irq = 4'b0000;
        tick();
        check_req("t5.present", 2'd3, 3'd1, 16'h0183);
        irq     = 4'b1000;
        int_ack = 1'b1;
        tick();
        irq     = 4'b0000;
        int_ack = 1'b0;
        check("t5.ack.pending", 32'(pending), 32'h8);
        check("t5.ack.req", 32'(int_req), 32'd0);
        tick();
        check("t5.idle.req", 32'(int_req), 32'd0);
        tick();
        check_req("t5.again", 2'd3, 3'd1, 16'h0183);

        // Asynchronous reset in REQ takes effect without a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("t5.rst.req",     32'(int_req), 32'd0);
        check("t5.rst.pending", 32'(pending), 32'd0);
        check("t5.rst.mask",    32'(mask),    32'd0);
        check("t5.rst.vec",     32'(int_vec), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("t5.after");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_lc3_int_ctrl
`default_nettype wire
